// File: rtl/riscv_pkg.sv
// Shared decode-stage definitions: immediate-select encodings, skid buffer
// states and the combinational immediate extender.
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100,
    IMM_Z = 3'b101
  } imm_src_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Returns {err, value} with value extended to 64 bits; callers narrow it
  // to their XLEN. The sign always comes from instr[31].
  function automatic logic [64:0] imm_extend(input logic [31:0] instr,
                                             input logic [2:0]  imm_src);
    logic [63:0] v;
    logic        err;
    v   = '0;
    err = 1'b0;
    case (imm_src)
      IMM_I: v = {{52{instr[31]}}, instr[31:20]};
      IMM_S: v = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: v = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                  instr[11:8], 1'b0};
      IMM_U: v = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_J: v = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                  instr[30:21], 1'b0};
      IMM_Z: v = {59'b0, instr[19:15]};
      default: begin
        v   = '0;
        err = 1'b1;
      end
    endcase
    return {err, v};
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry skid buffer: main register drives the outputs, skid register
// absorbs the one extra entry accepted while downstream stalls.
module imm_skid_buf
  import riscv_pkg::*;
#(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   state_q;
  logic [W-1:0] main_q, skid_q;
  logic         vld_q, rdy_q;
  logic         acc, drn;

  // Ready is a register (only gated by rst) so out_ready never reaches in_ready
  assign in_ready  = rdy_q && !rst;
  assign out_valid = vld_q;
  assign out_data  = main_q;
  assign acc       = in_valid && in_ready;
  assign drn       = vld_q && out_ready;

  // EMPTY/ONE/TWO occupancy FSM with registered valid/ready flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else if (flush) begin
      state_q <= BUF_EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (acc) begin
            main_q  <= in_data;
            vld_q   <= 1'b1;
            state_q <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (acc && !drn) begin
            skid_q  <= in_data;
            rdy_q   <= 1'b0;
            state_q <= BUF_TWO;
          end else if (acc && drn) begin
            main_q  <= in_data;
          end else if (drn) begin
            vld_q   <= 1'b0;
            state_q <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          // in_ready is low here, so only a drain can happen
          if (drn) begin
            main_q  <= skid_q;
            rdy_q   <= 1'b1;
            state_q <= BUF_ONE;
          end
        end
        default: begin
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= BUF_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: extends the immediate combinationally and
// stores {err, imm, tag} in a two-entry skid buffer. XLEN is 32 or 64.
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             imm_err
);

  localparam int W = XLEN + TAG_W + 1;

  logic [XLEN-1:0] imm_w;
  logic            err_w;
  logic [W-1:0]    pld_in, pld_out;

  // Narrow the 64-bit extension result to XLEN; the error flag sits above it
  assign imm_w  = XLEN'(imm_extend(instr, imm_src));
  assign err_w  = 1'(imm_extend(instr, imm_src) >> 64);
  assign pld_in = {err_w, imm_w, in_tag};

  imm_skid_buf #(.W(W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pld_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pld_out)
  );

  assign {imm_err, imm_out, out_tag} = pld_out;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and
// are compared every cycle against a queue-based FIFO model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  imm_src = '0;
  logic [4:0]  in_tag = '0;

  logic        in_ready, out_valid, imm_err;
  logic [31:0] imm_out;
  logic [4:0]  out_tag;
  logic        in_ready64, out_valid64, imm_err64;
  logic [63:0] imm_out64;
  logic [4:0]  out_tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .imm_out(imm_out), .out_tag(out_tag), .imm_err(imm_err));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .imm_out(imm_out64), .out_tag(out_tag64), .imm_err(imm_err64));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        err;
  } ent_t;

  ent_t       q[$];
  logic [4:0] drained[$];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Immediate as an integer: gather the field, then sign-extend arithmetically
  function automatic void ref_ext(input logic [31:0] ins, input logic [2:0] src,
                                  output logic [63:0] v, output logic e);
    longint raw;
    int     bits;
    e = 1'b0; raw = 0; bits = 0;
    case (src)
      3'd0: begin raw = longint'(ins >> 20); bits = 12; end
      3'd1: begin raw = longint'(((ins >> 25) << 5) | ((ins >> 7) & 32'h1F)); bits = 12; end
      3'd2: begin
        raw = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
            + longint'((ins >> 25) & 32'h3F) * 32 + longint'((ins >> 8) & 32'hF) * 2;
        bits = 13;
      end
      3'd3: begin raw = longint'(ins & 32'hFFFFF000); bits = 32; end
      3'd4: begin
        raw = longint'(ins[31]) * (64'd1 << 20) + longint'((ins >> 12) & 32'hFF) * 4096
            + longint'(ins[20]) * 2048 + longint'((ins >> 21) & 32'h3FF) * 2;
        bits = 21;
      end
      3'd5: begin raw = longint'((ins >> 15) & 32'h1F); bits = 0; end
      default: e = 1'b1;
    endcase
    if (bits > 0 && raw[bits-1]) raw = raw - (longint'(1) << bits);
    v = raw;
  endfunction

  // Compare both DUTs against the model, then advance the model by this cycle's handshakes
  always @(negedge clk) begin : mon
    logic exp_rdy, acc, drn;
    ent_t e;
    exp_rdy = !rst && (q.size() < 2);
    check("in_ready", in_ready, exp_rdy);
    check("in_ready64", in_ready64, exp_rdy);
    check("out_valid", out_valid, q.size() > 0);
    check("out_valid64", out_valid64, q.size() > 0);
    if (q.size() > 0) begin
      check("imm_out", imm_out, q[0].imm[31:0]);
      check("imm_out64", imm_out64, q[0].imm);
      check("out_tag", out_tag, q[0].tag);
      check("out_tag64", out_tag64, q[0].tag);
      check("imm_err", imm_err, q[0].err);
      check("imm_err64", imm_err64, q[0].err);
    end
    acc = in_valid && exp_rdy;
    drn = (q.size() > 0) && out_ready;
    if (rst) begin
      q.delete();
    end else begin
      if (drn) begin
        drained.push_back(q[0].tag);
        void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (acc) begin
        ref_ext(instr, imm_src, e.imm, e.err);
        e.tag = in_tag;
        q.push_back(e);
      end
    end
  end

  task automatic send_chk(input logic [31:0] ins, input logic [2:0] s, input logic [4:0] t,
                          input logic [63:0] e64, input logic e_err, input string nm);
    in_valid = 1'b1; instr = ins; imm_src = s; in_tag = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_imm32"}, imm_out, e64[31:0]);
    check({nm, "_imm64"}, imm_out64, e64);
    check({nm, "_err"}, imm_err, e_err);
    check({nm, "_tag"}, out_tag, t);
  endtask

  initial begin
    int         hits;
    logic [31:0] held;

    // Reset state
    @(negedge clk);
    check("rst_imm", imm_out64, 0);
    check("rst_tag", out_tag, 0);
    check("rst_err", imm_err, 0);
    check("rst_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);

    // Directed encodings, full throughput
    out_ready = 1'b1;
    send_chk(32'hFFF00093, 3'd0, 5'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0, "I");
    send_chk(32'hFE20AE23, 3'd1, 5'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0, "S");
    send_chk(32'hFE000CE3, 3'd2, 5'd3, 64'hFFFFFFFFFFFFFFF8, 1'b0, "B");
    send_chk(32'h0010006F, 3'd4, 5'd4, 64'h0000000000000800, 1'b0, "J");
    send_chk(32'h800002B7, 3'd3, 5'd5, 64'hFFFFFFFF80000000, 1'b0, "U");
    send_chk(32'h800F8073, 3'd5, 5'd6, 64'h000000000000001F, 1'b0, "Z");
    send_chk(32'hFFFFFFFF, 3'd7, 5'd7, 64'h0, 1'b1, "ILL");

    // Back-pressure: tags 1,2 accepted, 3 waits, tag 1 held
    @(posedge clk); #1;
    out_ready = 1'b0; drained.delete();
    in_valid = 1'b1; in_tag = 5'd1; instr = $urandom; imm_src = 3'd0;
    @(posedge clk); #1 in_tag = 5'd2; instr = $urandom;
    @(posedge clk); #1 in_tag = 5'd3; instr = $urandom;
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_hold_tag", out_tag, 1);
    held = imm_out;
    repeat (3) begin
      @(negedge clk);
      check("bp_stable_tag", out_tag, 1);
      check("bp_stable_imm", imm_out, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 20 && drained.size() < 3; i++) @(posedge clk);
    check("bp_count", drained.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < drained.size()) check("bp_order", drained[i], i + 1);

    // Flush in TWO with a fresh entry offered
    @(posedge clk); #1;
    out_ready = 1'b0; drained.delete();
    in_valid = 1'b1; in_tag = 5'd4;
    @(posedge clk); #1 in_tag = 5'd5;
    @(posedge clk); #1 in_tag = 5'd9; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    hits = 0;
    foreach (drained[i]) if (drained[i] == 5'd9) hits++;
    check("flush_dropped", hits, 0);
    check("flush_no_stale", drained.size(), 0);

    // Reset mid-stream in TWO
    @(posedge clk); #1;
    out_ready = 1'b0; drained.delete();
    in_valid = 1'b1; in_tag = 5'd6;
    @(posedge clk); #1 in_tag = 5'd7;
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_imm", imm_out, 0);
    check("rst_mid_ready_after", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    check("rst_no_stale", drained.size(), 0);

    // Randomized traffic
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 200) == 0);
      instr     = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the RISC-V pipeline's decode stage. It accepts an instruction word and an immediate-type select through a valid/ready handshake and produces the XLEN-wide extended immediate one cycle later, together with a pass-through tag. A two-entry skid buffer sustains full throughput under back-pressure, and a synchronous flush discards in-flight entries on branch redirect. It adds RV64 support, a CSR zero-extended (Z) type and an illegal-select flag.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag (rd, PC index, etc.) carried alongside the immediate.

- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; discards all held entries.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  stage can accept an entry.
- instr  input  32  instruction word; only bits [31:7] are used.
- imm_src  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 Z, 110/111 illegal.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- imm_out  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag belonging to imm_out.
- imm_err  output  1  the entry had an illegal imm_src.

## Operation
- **I-type:** sext(instr[31:20]).
- **S-type:** sext({instr[31:25], instr[11:7]}).
- **B-type:** sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- **U-type:** sext({instr[31:12], 12'b0}). For XLEN=64, bits [63:32] replicate instr[31].
- **J-type:** sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- **Z-type:** zero-extend instr[19:15]. instr[31] is ignored.
- **Illegal select (110/111):** imm_out = 0 and imm_err = 1.
- **Sign extension:** all sext is to XLEN, taking the sign from instr[31].
- **Handshake:** a transfer occurs on a cycle where valid and ready are both high, on either side.
- **Buffer state machine:** states EMPTY, ONE (main register valid) and TWO (main and skid registers valid).
  - EMPTY + accept → ONE.
  - ONE + accept + no drain → TWO.
  - ONE + drain + no accept → EMPTY.
  - ONE + accept + drain → ONE, with the new entry in main.
  - TWO + drain → ONE, with skid moving to main. No accept is possible in TWO.
- **Port relations:** in_ready = !skid_valid && !rst. out_valid = main_valid.
- **Ordering:** entries leave in acceptance order. There is no reordering and no duplication.
- **Output stability:** while out_valid && !out_ready, imm_out, out_tag and imm_err hold stable.
- **Flush:** takes priority over accept and drain in the same cycle. Next state is EMPTY. An input offered in the flush cycle is dropped. A drain in the flush cycle still counts as delivered downstream.
- **Reset:** all valid bits, imm_out, out_tag and imm_err go to 0. out_valid = 0. in_ready = 0 while rst is high, and 1 in the first cycle after release.

## Timing
- **Latency:** 1 cycle from accept to out_valid, with imm_out registered.
- **Throughput:** 1 entry per cycle while out_ready is held high.
- **Back-pressure:** one additional entry is absorbed into skid, then in_ready drops in the following cycle. in_ready is registered (apart from the rst gating) and has no combinational path from out_ready.
- **Recovery:** in_ready returns high in the cycle after a drain from TWO.
- **Flush recovery:** out_valid = 0 in the cycle after flush, and in_ready = 1.

## Structure
- **Shared package `riscv_pkg`:**
  - imm_src encodings IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z.
  - XLEN default.
  - A function imm_extend(instr, imm_src) that returns {err, value}.
- **Sub-module `imm_skid_buf`:** a natural split, parametrised on payload width (XLEN+TAG_W+1), owning the EMPTY/ONE/TWO state machine. imm_gen_pipe is the extend function feeding imm_skid_buf.

## Test plan
- **I and S, XLEN=32, out_ready=1:** instr 0xFFF00093 with I → imm_out 0xFFFFFFFF one cycle later. Next cycle, 0xFE20AE23 with S → 0xFFFFFFFC.
- **B, J and U:**
  - 0xFE000CE3 with B → 0xFFFFFFF8.
  - 0x0010006F with J → 0x00000800.
  - 0x800002B7 with U → 0x80000000 at XLEN=32, and 0xFFFFFFFF80000000 at XLEN=64.
- **Z and illegal:** instr[31]=1, instr[19:15]=5'b11111 with Z → 0x0000001F, imm_err=0. imm_src=111 → imm_out 0, imm_err=1.
- **Back-pressure:** stream tags 1,2,3 with out_ready=0.
  - Tags 1 and 2 are accepted; in_ready=0 from the third cycle.
  - Tag 1 is held stable on the outputs.
  - Raise out_ready → tags 1, 2 and 3 are emitted in order, with no loss.
- **Flush in state TWO with in_valid=1:** next cycle out_valid=0 and in_ready=1. The entry offered in the flush cycle never appears on the output.
- **Reset mid-stream (state TWO):** rst for 1 cycle → out_valid=0, imm_out=0, in_ready=0 during rst. in_ready=1 after release, and no stale entries are emitted.
